// File: rtl/ram_line_if.sv
// Cache-to-RAM line bus: request strobe, write beats in, read beats and ack out.
// The slave modport is the RAM end; dbg_state mirrors the responder FSM state.
interface ram_line_if #(
  parameter int ADDR_SIZE  = 13,
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WIDTH = 64
);
  logic [ADDR_SIZE-1:0]  ram_addr;
  logic                  ram_avalid;
  logic                  ram_rnw;
  logic [WORD_SIZE-1:0]  ram_wdata;
  logic [WORD_SIZE-1:0]  ram_rdata;
  logic                  ram_ack;
  logic                  ram_err;
  logic [LINE_WIDTH-1:0] data_backdoor;
  logic [2:0]            dbg_state;

  modport master (
    output ram_addr, ram_avalid, ram_rnw, ram_wdata,
    input  ram_rdata, ram_ack, ram_err, data_backdoor, dbg_state
  );

  modport slave (
    input  ram_addr, ram_avalid, ram_rnw, ram_wdata,
    output ram_rdata, ram_ack, ram_err, data_backdoor, dbg_state
  );
endinterface

// File: rtl/ram_line_responder.sv
// Synthesizable RAM end of the cache refill/writeback link: 4-beat line reads and writes.
// Optional build macro RAM_PATTERN_FILL_EN: unwritten lines read as generated beats instead of zeros.
module ram_line_responder #(
  parameter int ADDR_SIZE  = 13,
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WIDTH = 64,
  parameter int LATENCY    = 2
) (
  input logic       ram_clk,
  input logic       ram_rst_n,
  ram_line_if.slave bus
);

  localparam int         DEPTH     = 1 << ADDR_SIZE;
  localparam logic [3:0] WAIT_LAST = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WCAP   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WACK   = 3'd3,
    ST_RBURST = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             beat_q;
  logic [3:0]             wait_q;
  logic                   is_read_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]  line_q;
  logic [LINE_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]       line_valid;
  logic [WORD_SIZE-1:0]   rdata_q;
  logic                   ack_q;
  logic                   err_q;
  logic [LINE_WIDTH-1:0]  backdoor_q;

  logic                   accept;
  logic                   commit;
  logic [LINE_WIDTH-1:0]  commit_line;
  logic [LINE_WIDTH-1:0]  fetch_line;
  logic [LINE_WIDTH-1:0]  burst_src;
  logic [1:0]             next_beat;

`ifdef RAM_PATTERN_FILL_EN
  function automatic logic [WORD_SIZE-1:0] fill_beat(input logic [ADDR_SIZE-1:0] a,
                                                     input logic [1:0] k);
    logic [WORD_SIZE-1:0] w;
    w                    = '0;
    w[ADDR_SIZE-1:0]     = a;
    w[WORD_SIZE-3]       = 1'b1;
    w[WORD_SIZE-1 -: 2]  = k;
    return w;
  endfunction
`endif

  // Handshake: ram_avalid is a one-cycle strobe with an implicit ready that is
  // high only in ST_IDLE; a strobe seen in any other state is dropped and sets ram_err.
  assign accept      = (state_q == ST_IDLE) && bus.ram_avalid;
  assign commit      = (state_q == ST_WCAP) && (beat_q == 2'd3);
  assign commit_line = {bus.ram_wdata, line_q[3*WORD_SIZE-1:0]};
  assign next_beat   = (state_q == ST_RBURST) ? beat_q + 2'd1 : 2'd0;
  // With zero latency the first beat leaves straight from the array lookup.
  assign burst_src   = (state_q == ST_IDLE) ? fetch_line : line_q;

  always_comb begin
    fetch_line = '0;
`ifdef RAM_PATTERN_FILL_EN
    for (int k = 0; k < 4; k++) begin
      fetch_line[k*WORD_SIZE +: WORD_SIZE] = fill_beat(bus.ram_addr, 2'(k));
    end
`endif
    if (line_valid[bus.ram_addr]) fetch_line = mem[bus.ram_addr];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ram_avalid) begin
          if (bus.ram_rnw) state_d = (LATENCY == 0) ? ST_RBURST : ST_WAIT;
          else             state_d = ST_WCAP;
        end
      end
      ST_WCAP:   if (beat_q == 2'd3) state_d = (LATENCY == 0) ? ST_WACK : ST_WAIT;
      ST_WAIT:   if (wait_q == WAIT_LAST) state_d = is_read_q ? ST_RBURST : ST_WACK;
      ST_WACK:   state_d = ST_IDLE;
      ST_RBURST: if (beat_q == 2'd3) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      wait_q     <= '0;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      line_q     <= '0;
      line_valid <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      backdoor_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ST_WACK) || (state_d == ST_RBURST);
      wait_q  <= (state_q == ST_WAIT) ? wait_q + 4'd1 : 4'd0;
      if (bus.ram_avalid && (state_q != ST_IDLE)) err_q <= 1'b1;

      if (accept) begin
        is_read_q <= bus.ram_rnw;
        addr_q    <= bus.ram_addr;
        beat_q    <= bus.ram_rnw ? 2'd0 : 2'd1;
        if (bus.ram_rnw) line_q <= fetch_line;
        else             line_q[WORD_SIZE-1:0] <= bus.ram_wdata;
      end else if ((state_q == ST_WCAP) || (state_q == ST_RBURST)) begin
        beat_q <= beat_q + 2'd1;
      end

      if (state_q == ST_WCAP) line_q[beat_q*WORD_SIZE +: WORD_SIZE] <= bus.ram_wdata;

      if (commit) begin
        line_valid[addr_q] <= 1'b1;
        backdoor_q         <= commit_line;
      end

      // rdata only moves while a burst is presented, so it holds the last beat afterwards.
      if (state_d == ST_RBURST) rdata_q <= burst_src[next_beat*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge ram_clk) begin
    if (commit) mem[addr_q] <= commit_line;
  end

  assign bus.ram_rdata     = rdata_q;
  assign bus.ram_ack       = ack_q;
  assign bus.ram_err       = err_q;
  assign bus.data_backdoor = backdoor_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_ram_line_responder.sv
// Bench for ram_line_responder: line-level model with per-cycle compare, directed
// scenarios, randomized traffic, and a zero-latency instance.
module tb_ram_line_responder;

  localparam int AW  = 13;
  localparam int WW  = 16;
  localparam int LW  = 64;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_line_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LINE_WIDTH(LW)) bus  ();
  ram_line_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LINE_WIDTH(LW)) bus0 ();

  ram_line_responder #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LINE_WIDTH(LW), .LATENCY(LAT)) dut (
    .ram_clk   (clk),
    .ram_rst_n (rst_n),
    .bus       (bus)
  );

  ram_line_responder #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LINE_WIDTH(LW), .LATENCY(0)) dut0 (
    .ram_clk   (clk),
    .ram_rst_n (rst_n),
    .bus       (bus0)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [LW-1:0] m_mem [logic [AW-1:0]];
  int            ack_kind [int];        // cycle -> 1 write ack, 2 read beat
  logic [LW-1:0] bd_sched [int];        // cycle -> backdoor value from that cycle on
  logic [WW-1:0] exp_q [$];             // read beats in order
  logic [WW-1:0] exp_last;
  logic [LW-1:0] exp_bd;
  int            err_at;
  int            busy_until;

  function automatic logic [WW-1:0] m_fill(input logic [AW-1:0] a, input int k);
`ifdef RAM_PATTERN_FILL_EN
    logic [1:0] kk;
    kk = 2'(k);
    return {kk, 1'b1, a};
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    m_mem.delete();
    ack_kind.delete();
    bd_sched.delete();
    exp_q.delete();
    exp_last   = '0;
    exp_bd     = '0;
    err_at     = 32'h7fff_ffff;
    busy_until = -1;
  endtask

  // A request is taken only once every ack of the previous one has been seen.
  task automatic model_request(input int t0, input logic rnw, input logic [AW-1:0] a,
                               input logic [LW-1:0] wline);
    logic [LW-1:0] l;
    if (t0 <= busy_until) begin
      if (err_at > t0 + 1) err_at = t0 + 1;
      return;
    end
    busy_until = t0 + 4 + LAT;
    if (!rnw) begin
      m_mem[a]              = wline;
      bd_sched[t0 + 4]      = wline;
      ack_kind[t0 + 4 + LAT] = 1;
    end else begin
      if (m_mem.exists(a)) l = m_mem[a];
      else for (int k = 0; k < 4; k++) l[16*k +: 16] = m_fill(a, k);
      for (int k = 0; k < 4; k++) begin
        ack_kind[t0 + 1 + LAT + k] = 2;
        exp_q.push_back(l[16*k +: 16]);
      end
    end
  endtask

  // ---------------- compare / monitor ----------------
  int            obs_cyc [$];
  logic [WW-1:0] obs_dat [$];
  int            obs0_cyc [$];
  logic [WW-1:0] obs0_dat [$];

  always @(negedge clk) begin
    int kind;
    if (!rst_n) begin
      chk("ack_in_reset", bus.ram_ack, 0);
      chk("rdata_in_reset", bus.ram_rdata, 0);
      chk("err_in_reset", bus.ram_err, 0);
      chk("backdoor_in_reset", bus.data_backdoor, 0);
    end else begin
      if (bd_sched.exists(cyc)) begin
        exp_bd = bd_sched[cyc];
        bd_sched.delete(cyc);
      end
      kind = ack_kind.exists(cyc) ? ack_kind[cyc] : 0;
      chk("ack", bus.ram_ack, (kind != 0) ? 1 : 0);
      if (kind == 2) begin
        if (exp_q.size() == 0) chk("exp_q_underflow", 1, 0);
        else exp_last = exp_q.pop_front();
      end
      chk("rdata", bus.ram_rdata, exp_last);
      chk("err", bus.ram_err, (cyc >= err_at) ? 1 : 0);
      chk("backdoor", bus.data_backdoor, exp_bd);
      if (bus.ram_ack) begin
        obs_cyc.push_back(cyc);
        obs_dat.push_back(bus.ram_rdata);
      end
    end
    if (rst_n && bus0.ram_ack) begin
      obs0_cyc.push_back(cyc);
      obs0_dat.push_back(bus0.ram_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    step(n);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (cyc < busy_until && guard < 200) begin
      step(1);
      guard++;
    end
    if (guard >= 200) chk("wait_idle_timeout", 1, 0);
  endtask

  // abort_at = 1..3 asserts reset in that beat cycle instead of driving it.
  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] line,
                          input int abort_at, output int t0);
    @(posedge clk);
    #1;
    t0 = cyc;
    model_request(t0, 1'b0, a, line);
    bus.ram_avalid = 1'b1;
    bus.ram_rnw    = 1'b0;
    bus.ram_addr   = a;
    bus.ram_wdata  = line[15:0];
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      #1;
      bus.ram_avalid = 1'b0;
      bus.ram_rnw    = 1'($urandom);
      bus.ram_addr   = AW'($urandom);
      if (k == abort_at) begin
        rst_n = 1'b0;
        model_reset();
        break;
      end
      bus.ram_wdata = line[16*k +: 16];
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int t0);
    @(posedge clk);
    #1;
    t0 = cyc;
    model_request(t0, 1'b1, a, '0);
    bus.ram_avalid = 1'b1;
    bus.ram_rnw    = 1'b1;
    bus.ram_addr   = a;
    @(posedge clk);
    #1;
    bus.ram_avalid = 1'b0;
    bus.ram_rnw    = 1'($urandom);
    bus.ram_addr   = AW'($urandom);
    bus.ram_wdata  = WW'($urandom);
  endtask

  task automatic check_beats(input string name, input int first, input logic [LW-1:0] line);
    chk({name, "_count"}, obs_cyc.size(), 4);
    if (obs_cyc.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk({name, "_cycle"}, obs_cyc[k], first + k);
        chk({name, "_beat"}, obs_dat[k], line[16*k +: 16]);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  logic [LW-1:0] lit;
  logic [LW-1:0] rline;
  logic [AW-1:0] pool [6];
  int t0, t1;

  initial begin
    bus.ram_avalid  = 1'b0;
    bus.ram_rnw     = 1'b0;
    bus.ram_addr    = '0;
    bus.ram_wdata   = '0;
    bus0.ram_avalid = 1'b0;
    bus0.ram_rnw    = 1'b0;
    bus0.ram_addr   = '0;
    bus0.ram_wdata  = '0;
    model_reset();
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Read of an unwritten line after reset.
`ifdef RAM_PATTERN_FILL_EN
    lit = 64'hEABC_AABC_6ABC_2ABC;
`else
    lit = 64'h0;
`endif
    obs_cyc.delete(); obs_dat.delete();
    do_read(13'h0ABC, t0);
    step(8);
    check_beats("fresh_read", t0 + 3, lit);

    // Write then read back 0x0BBC.
    obs_cyc.delete(); obs_dat.delete();
    do_write(13'h0BBC, 64'hdeadbeef10009bbc, 0, t0);
    step(1);
    chk("backdoor_after_T3", bus.data_backdoor, 64'hdeadbeef10009bbc);
    wait_idle();
    step(2);
    chk("write_ack_count", obs_cyc.size(), 1);
    if (obs_cyc.size() > 0) chk("write_ack_cycle", obs_cyc[0], t0 + 6);
    obs_cyc.delete(); obs_dat.delete();
    do_read(13'h0BBC, t0);
    step(8);
    check_beats("readback", t0 + 3, 64'hdeadbeef10009bbc);

    // Back-to-back: read issued the cycle after the write ack.
    obs_cyc.delete(); obs_dat.delete();
    do_write(13'h0A00, 64'h0123_4567_89ab_cdef, 0, t1);
    wait_idle();
    do_read(13'h0A00, t0);
    step(8);
    chk("b2b_count", obs_cyc.size(), 5);
    if (obs_cyc.size() == 5) begin
      chk("b2b_write_ack", obs_cyc[0], t1 + 6);
      chk("b2b_read_first", obs_cyc[1], t1 + 10);
      chk("b2b_beat3", obs_dat[4], 16'h0123);
    end
    chk("b2b_err", bus.ram_err, 0);

    // Stray strobe during a burst.
    obs_cyc.delete(); obs_dat.delete();
    do_read(13'h0BBC, t0);
    step(2);
    @(posedge clk);
    #1;
    model_request(cyc, 1'b1, 13'h0A00, '0);
    bus.ram_avalid = 1'b1;
    bus.ram_rnw    = 1'b1;
    bus.ram_addr   = 13'h0A00;
    step(1);
    bus.ram_avalid = 1'b0;
    step(10);
    check_beats("burst_stray", t0 + 3, 64'hdeadbeef10009bbc);
    chk("stray_err", bus.ram_err, 1);

    // Reset in the middle of a write.
    do_write(13'h0100, 64'h1111_2222_3333_4444, 0, t0);
    wait_idle();
    step(1);
    obs_cyc.delete(); obs_dat.delete();
    do_write(13'h0100, 64'h5555_6666_7777_8888, 2, t0);
    step(2);
    rst_n = 1'b1;
    step(10);
    chk("aborted_write_acks", obs_cyc.size(), 0);
`ifdef RAM_PATTERN_FILL_EN
    lit = 64'hE100_A100_6100_2100;
`else
    lit = 64'h0;
`endif
    do_read(13'h0100, t0);
    step(8);
    check_beats("after_abort", t0 + 3, lit);

    // Randomized traffic, mostly well-spaced, occasionally colliding.
    pool[0] = 13'h0ABC; pool[1] = 13'h0BBC; pool[2] = 13'h1FFF;
    pool[3] = 13'h0000; pool[4] = AW'($urandom); pool[5] = AW'($urandom);
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 7) != 0) wait_idle();
      if ($urandom_range(0, 1) == 1) begin
        rline = {$urandom, $urandom};
        do_write(pool[$urandom_range(0, 5)], rline, 0, t0);
      end else begin
        do_read(pool[$urandom_range(0, 5)], t0);
      end
    end
    wait_idle();
    step(4);
    chk("exp_q_drained", exp_q.size(), 0);

    // Zero-latency instance.
    lit = 64'hc0de_f00d_0bad_1234;
    obs0_cyc.delete(); obs0_dat.delete();
    @(posedge clk);
    #1;
    t0 = cyc;
    bus0.ram_avalid = 1'b1;
    bus0.ram_rnw    = 1'b0;
    bus0.ram_addr   = 13'h0123;
    bus0.ram_wdata  = lit[15:0];
    for (int k = 1; k < 4; k++) begin
      step(1);
      bus0.ram_avalid = 1'b0;
      bus0.ram_wdata  = lit[16*k +: 16];
    end
    step(5);
    chk("l0_write_ack_count", obs0_cyc.size(), 1);
    if (obs0_cyc.size() > 0) chk("l0_write_ack_cycle", obs0_cyc[0], t0 + 4);
    chk("l0_backdoor", bus0.data_backdoor, lit);
    obs0_cyc.delete(); obs0_dat.delete();
    @(posedge clk);
    #1;
    t0 = cyc;
    bus0.ram_avalid = 1'b1;
    bus0.ram_rnw    = 1'b1;
    step(1);
    bus0.ram_avalid = 1'b0;
    step(6);
    chk("l0_read_count", obs0_cyc.size(), 4);
    if (obs0_cyc.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("l0_read_cycle", obs0_cyc[k], t0 + 1 + k);
        chk("l0_read_beat", obs0_dat[k], lit[16*k +: 16]);
      end
    end
    chk("l0_err", bus0.ram_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
